t05_huffman_decoder: RTL and testbench
======================================

# t05_huffman_decoder

Receive-side counterpart of the codebook synthesis stage in the team 05 Huffman compressor. Consumes the serial compressed bitstream one bit at a time and walks the Huffman tree held in SRAM, fetching one node per step, from root to leaf. Each leaf reached emits one 8-bit character. The block sits between the bitstream reader and the output byte writer, and runs only while the top-level controller is in the decode state.

## Interface
- Parameters: none; widths fixed by the tree-node format.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `en_state`  in  4  top-level state. Block advances only when `en_state == 4'd6`; otherwise all registers hold.
- `max_index`  in  7  root node index.
- `bit_in`  in  1  next code bit: 0 selects left child, 1 selects right child.
- `bit_valid`  in  1  `bit_in` valid.
- `bit_ready`  out  1  bit accepted this cycle when `bit_valid & bit_ready`.
- `stream_done`  in  1  level; no further bits will arrive.
- `node_rd`  out  1  one-cycle SRAM read request pulse.
- `node_addr`  out  7  node address; equals child index × 2, or `max_index` for the root.
- `node_data`  in  71  node word; left child at [63:55], right child at [54:46].
- `read_complete`  in  1  `node_data` valid this cycle.
- `char_out`  out  8  decoded character.
- `char_valid`  out  1  `char_out` valid; held until accepted.
- `char_ready`  in  1  consumer accepts when `char_valid & char_ready`.
- `finished`  out  1  decode complete (sticky until reset).
- `error`  out  1  null child (9'h180) selected (sticky until reset).
- `char_count`  out  16  characters emitted, wraps at 2^16.

## Operation
- Child field, 9 bits:
  - bit8=1: internal node; next address = field[6:0] × 2, truncated to 7 bits.
  - bit8=0: leaf; character = field[7:0].
  - 9'h180: null.
- States:
  - IDLE → FETCH_ROOT when enabled.
  - FETCH_ROOT: assert `node_rd` for 1 cycle with `node_addr = max_index` → WAIT.
  - WAIT: on `read_complete`, latch `node_data` into the node register → WALK.
  - WALK: `bit_ready = 1`.
    - On handshake, select the left or right field.
    - Null → ERR.
    - Leaf → EMIT with `char_out` = field[7:0].
    - Internal → FETCH_CHILD with the address computed from the field.
    - If `stream_done & !bit_valid` → DONE.
  - FETCH_CHILD: `node_rd` pulse at the child address → WAIT.
  - EMIT: `char_valid = 1`. On `char_ready`, increment `char_count` → FETCH_ROOT.
  - DONE: `finished = 1`, terminal.
  - ERR: `error = 1`, terminal.
- `stream_done` observed mid-code (outside FETCH_ROOT/WALK at the root) does not stop the walk. The block finishes the current code. If no bit is available in WALK at a non-root node, it raises `error` (truncated code).
- Only one SRAM read is outstanding at a time. `read_complete` outside WAIT is ignored.
- A degenerate tree whose root has a leaf child emits that leaf for each 1-bit code.

## Timing
- Reset values:
  - state IDLE.
  - `node_rd`, `bit_ready`, `char_valid`, `finished`, `error` = 0.
  - `node_addr` = 0, `char_out` = 0, `char_count` = 0.
- All outputs are registered except `bit_ready`, which is decoded from state.
- Minimum per-bit cost, with zero-latency SRAM (`read_complete` the cycle after `node_rd`): FETCH, WAIT, WALK = 3 cycles.
- Minimum per-character overhead: EMIT + FETCH_ROOT + WAIT = 3 cycles.
- `en_state != 6` mid-operation freezes state, including a pending WAIT. A `read_complete` that arrives while frozen is lost, so the controller must not leave decode with a read outstanding.
- `char_valid` with `char_ready` low stalls indefinitely; `char_out` must stay stable.
- `rst` mid-operation returns to IDLE immediately. The in-flight SRAM read is abandoned.

## Structure
- Shared package `t05_huff_pkg`:
  - node field positions: LEFT_HI = 63, RIGHT_HI = 54.
  - NULL_NODE = 9'h180.
  - decode state encoding 4'd6.
  - state enum.
- One natural sub-module: `t05_node_fetch`, the read-request/latch handshake that owns `node_rd`, `node_addr`, and the node register.

## Test plan
- Three-node tree: root at max_index = 4 with left leaf 'A' (9'h041) and right leaf 'B' (9'h042). Bits 0,1,1 → `char_out` 'A','B','B'; `char_count` = 3; then `stream_done` → `finished = 1`.
- Two-level tree: root right child is internal index 3, so the fetch address is 6. Bits 1,0 → `node_addr` sequence 4, 6, 4; one char from node 6 left.
- SRAM latency of 5 cycles between `node_rd` and `read_complete` → `bit_ready` stays low throughout; output matches the zero-latency run.
- `char_ready` held low for 10 cycles in EMIT → `char_valid` and `char_out` stable; no bit accepted.
- Selected child = 9'h180 → `error = 1`; no further `node_rd`.
- `en_state` dropped to 3 for 4 cycles in WALK, then restored → decode resumes; identical output.

Source files
------------

// File: rtl/t05_huffman_decoder_pkg.sv
// Shared definitions for the team 05 Huffman decoder: tree-node field layout,
// decode-state code and the decoder walk-state enum.
package t05_huff_pkg;

  localparam int unsigned NODE_W  = 71;
  localparam int unsigned FIELD_W = 9;
  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned CHAR_W  = 8;
  localparam int unsigned COUNT_W = 16;

  localparam int unsigned LEFT_HI  = 63;
  localparam int unsigned RIGHT_HI = 54;

  localparam logic [FIELD_W-1:0] NULL_NODE    = 9'h180;
  localparam logic [3:0]         DECODE_STATE = 4'd6;

  typedef logic [FIELD_W-1:0] child_field_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_ROOT,
    S_WAIT,
    S_WALK,
    S_FETCH_CHILD,
    S_EMIT,
    S_DONE,
    S_ERR
  } dec_state_e;

  // Internal child index i lives at SRAM address 2*i, truncated to 7 bits.
  function automatic logic [ADDR_W-1:0] child_addr(input child_field_t f);
    return {f[ADDR_W-2:0], 1'b0};
  endfunction

  function automatic logic is_leaf(input child_field_t f);
    return !f[FIELD_W-1];
  endfunction

endpackage

// File: rtl/t05_huffman_decoder_if.sv
// Bitstream, node-SRAM and character-output handshakes of the Huffman decoder.
interface t05_huffman_decoder_if;
  import t05_huff_pkg::*;

  logic                bit_in;
  logic                bit_valid;
  logic                bit_ready;
  logic                stream_done;
  logic                node_rd;
  logic [ADDR_W-1:0]   node_addr;
  logic [NODE_W-1:0]   node_data;
  logic                read_complete;
  logic [CHAR_W-1:0]   char_out;
  logic                char_valid;
  logic                char_ready;

  modport master (
    output bit_ready, node_rd, node_addr, char_out, char_valid,
    input  bit_in, bit_valid, stream_done, node_data, read_complete, char_ready
  );

  modport slave (
    input  bit_ready, node_rd, node_addr, char_out, char_valid,
    output bit_in, bit_valid, stream_done, node_data, read_complete, char_ready
  );

endinterface

// File: rtl/t05_huffman_decoder_node_fetch.sv
// Node SRAM read handshake: registered read pulse/address and the latched
// left/right child fields of the current node.
module t05_node_fetch
  import t05_huff_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                req,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                latch,
  input  logic [NODE_W-1:0]   node_data,
  output logic                node_rd,
  output logic [ADDR_W-1:0]   node_addr,
  output child_field_t        left_field,
  output child_field_t        right_field
);

  // Only the two child fields of a node word matter to the walk.
  logic unused_node_bits;
  assign unused_node_bits = ^{node_data[NODE_W-1:LEFT_HI+1],
                              node_data[RIGHT_HI-FIELD_W:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      node_rd     <= 1'b0;
      node_addr   <= '0;
      left_field  <= '0;
      right_field <= '0;
    end else if (en) begin
      node_rd <= req;
      if (req) begin
        node_addr <= req_addr;
      end
      if (latch) begin
        left_field  <= node_data[LEFT_HI -: FIELD_W];
        right_field <= node_data[RIGHT_HI -: FIELD_W];
      end
    end
  end

endmodule

// File: rtl/t05_huffman_decoder.sv
// Huffman bitstream decoder: walks the SRAM-resident tree one code bit per
// node fetch and emits one character per leaf reached.
module t05_huffman_decoder
  import t05_huff_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [3:0]                en_state,
  input  logic [ADDR_W-1:0]         max_index,
  t05_huffman_decoder_if.master     bus,
  output logic                      finished,
  output logic                      error,
  output logic [COUNT_W-1:0]        char_count
);

  dec_state_e        state_q, state_d;
  logic              en;
  logic              at_root_q;
  logic              fetch_req;
  logic              fetch_root;
  logic [ADDR_W-1:0] fetch_addr;
  logic              latch;
  logic              emit_load;
  logic              char_take;
  logic              bit_ready_c;
  child_field_t      left_f, right_f, sel_f;
  logic [CHAR_W-1:0] char_q;
  logic              char_valid_q;

  assign en = (en_state == DECODE_STATE);

  t05_node_fetch u_fetch (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .req         (fetch_req),
    .req_addr    (fetch_addr),
    .latch       (latch),
    .node_data   (bus.node_data),
    .node_rd     (bus.node_rd),
    .node_addr   (bus.node_addr),
    .left_field  (left_f),
    .right_field (right_f)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else if (en) begin
      state_q <= state_d;
    end
  end

  // The read request is issued on the edge that enters a FETCH state, so the
  // pulse and address are registered yet the fetch still costs one cycle.
  always_comb begin
    state_d     = state_q;
    fetch_req   = 1'b0;
    fetch_root  = 1'b0;
    fetch_addr  = max_index;
    latch       = 1'b0;
    emit_load   = 1'b0;
    char_take   = 1'b0;
    bit_ready_c = 1'b0;
    sel_f       = bus.bit_in ? right_f : left_f;
    if (en) begin
      unique case (state_q)
        S_IDLE: begin
          state_d    = S_FETCH_ROOT;
          fetch_req  = 1'b1;
          fetch_root = 1'b1;
        end
        S_FETCH_ROOT, S_FETCH_CHILD: begin
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (bus.read_complete) begin
            latch   = 1'b1;
            state_d = S_WALK;
          end
        end
        S_WALK: begin
          bit_ready_c = 1'b1;
          if (bus.bit_valid) begin
            if (sel_f == NULL_NODE) begin
              state_d = S_ERR;
            end else if (is_leaf(sel_f)) begin
              state_d   = S_EMIT;
              emit_load = 1'b1;
            end else begin
              state_d    = S_FETCH_CHILD;
              fetch_req  = 1'b1;
              fetch_addr = child_addr(sel_f);
            end
          end else if (bus.stream_done) begin
            // Running dry part-way through a code means a truncated stream.
            state_d = at_root_q ? S_DONE : S_ERR;
          end
        end
        S_EMIT: begin
          if (bus.char_ready) begin
            char_take  = 1'b1;
            state_d    = S_FETCH_ROOT;
            fetch_req  = 1'b1;
            fetch_root = 1'b1;
          end
        end
        S_DONE, S_ERR: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      at_root_q    <= 1'b0;
      char_q       <= '0;
      char_valid_q <= 1'b0;
      char_count   <= '0;
      finished     <= 1'b0;
      error        <= 1'b0;
    end else if (en) begin
      if (fetch_req) begin
        at_root_q <= fetch_root;
      end
      if (emit_load) begin
        char_q       <= sel_f[CHAR_W-1:0];
        char_valid_q <= 1'b1;
      end
      if (char_take) begin
        char_valid_q <= 1'b0;
        char_count   <= char_count + 16'd1;
      end
      if (state_d == S_DONE) begin
        finished <= 1'b1;
      end
      if (state_d == S_ERR) begin
        error <= 1'b1;
      end
    end
  end

  assign bus.bit_ready  = bit_ready_c;
  assign bus.char_out   = char_q;
  assign bus.char_valid = char_valid_q;

endmodule

// File: tb/tb_t05_huffman_decoder.sv
// Directed bench for t05_huffman_decoder: tree-walk reference model, SRAM
// responder with configurable latency, and a per-cycle output comparator.
module tb_t05_huffman_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  en_state;
  logic [6:0]  max_index;
  logic        finished;
  logic        error;
  logic [15:0] char_count;

  t05_huffman_decoder_if bus();

  t05_huffman_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .en_state   (en_state),
    .max_index  (max_index),
    .bus        (bus),
    .finished   (finished),
    .error      (error),
    .char_count (char_count)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Tree contents, stimulus and reference model
  logic [8:0]  tl [128];
  logic [8:0]  tr [128];
  logic [70:0] mem [128];
  bit          stim[$];
  logic [7:0]  exp_chars[$];
  logic [6:0]  exp_addrs[$];
  bit          exp_fin, exp_err;

  task automatic clear_tree();
    for (int i = 0; i < 128; i++) begin
      tl[i] = 9'h180;
      tr[i] = 9'h180;
    end
  endtask

  task automatic load_mem();
    for (int i = 0; i < 128; i++)
      mem[i] = {7'h5A, tl[i], tr[i], 46'h2A5A_5A5A_5A5A};
  endtask

  function automatic void run_model(input logic [6:0] root);
    int         node;
    logic [8:0] f;
    bit         at_root;
    exp_chars.delete();
    exp_addrs.delete();
    exp_fin = 0;
    exp_err = 0;
    node    = int'(root);
    at_root = 1;
    exp_addrs.push_back(root);
    foreach (stim[i]) begin
      f = stim[i] ? tr[node] : tl[node];
      if (f == 9'h180) begin
        exp_err = 1;
        return;
      end
      if (f[8] == 1'b0) begin
        exp_chars.push_back(f[7:0]);
        node    = int'(root);
        at_root = 1;
      end else begin
        node    = (int'(f[6:0]) * 2) % 128;
        at_root = 0;
      end
      exp_addrs.push_back(7'(node));
    end
    if (at_root) exp_fin = 1;
    else         exp_err = 1;
  endfunction

  // SRAM responder
  int lat      = 0;
  int rd_count = 0;
  initial begin
    logic [6:0] a;
    bus.read_complete = 1'b0;
    bus.node_data     = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.node_rd && !rst) begin
        a = bus.node_addr;
        rd_count++;
        repeat (lat) @(posedge clk);
        @(posedge clk); #1;
        bus.read_complete = 1'b1;
        bus.node_data     = mem[a];
        @(posedge clk); #1;
        bus.read_complete = 1'b0;
      end
    end
  end

  // Bit source: main publishes a new feed by bumping feed_epoch
  bit feed[$];
  int feed_epoch = 0;
  initial begin
    int idx;
    int ep;
    bit acc;
    idx = 0;
    ep  = 0;
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
    forever begin
      @(negedge clk);
      acc = bus.bit_ready && bus.bit_valid;
      @(posedge clk); #1;
      if (ep != feed_epoch) begin
        ep  = feed_epoch;
        idx = 0;
      end else if (acc) begin
        idx++;
      end
      bus.bit_valid = (idx < feed.size());
      bus.bit_in    = bus.bit_valid ? feed[idx] : 1'b0;
    end
  end

  // Per-cycle comparator
  bit         checking = 0;
  int         ci, ai;
  bit         outstanding;
  logic [7:0] got_chars[$];
  logic [6:0] got_addrs[$];

  always @(negedge clk) begin
    if (checking) begin
      chk("char_count_live", char_count, ci);
      if (outstanding)
        chk("bit_ready_while_fetch", bus.bit_ready, 0);
      if (en_state != 4'd6)
        chk("bit_ready_frozen", bus.bit_ready, 0);
      if (bus.char_valid) begin
        chk("bit_ready_during_emit", bus.bit_ready, 0);
        if (ci < exp_chars.size()) chk("char_out", bus.char_out, exp_chars[ci]);
        else                       chk("char_valid_extra", bus.char_valid, 0);
        if (bus.char_ready) begin
          got_chars.push_back(bus.char_out);
          ci++;
        end
      end
      if (bus.node_rd) begin
        if (ai < exp_addrs.size()) chk("node_addr", bus.node_addr, exp_addrs[ai]);
        else                       chk("node_rd_extra", bus.node_rd, 0);
        got_addrs.push_back(bus.node_addr);
        ai++;
        outstanding = 1;
      end else if (bus.read_complete) begin
        outstanding = 0;
      end
    end
  end

  function automatic logic [7:0] gc(input int i);
    return (i < got_chars.size()) ? got_chars[i] : 8'hFF;
  endfunction

  function automatic logic [6:0] ga(input int i);
    return (i < got_addrs.size()) ? got_addrs[i] : 7'h7F;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en_state = 4'd0;
    bus.stream_done = 1'b0;
    bus.char_ready  = 1'b1;
    feed.delete();
    feed_epoch++;
    #1;
    chk("rst_node_rd",    bus.node_rd,    0);
    chk("rst_bit_ready",  bus.bit_ready,  0);
    chk("rst_char_valid", bus.char_valid, 0);
    chk("rst_finished",   finished,       0);
    chk("rst_error",      error,          0);
    chk("rst_node_addr",  bus.node_addr,  0);
    chk("rst_char_out",   bus.char_out,   0);
    chk("rst_char_count", char_count,     0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // mode 0: plain run; 1: char_ready held low 10 cycles; 2: freeze in WALK
  task automatic run_test(input string tname, input logic [6:0] root,
                          input int latency, input int mode);
    int k;
    do_reset();
    max_index = root;
    lat       = latency;
    load_mem();
    run_model(root);
    ci = 0; ai = 0; outstanding = 0; rd_count = 0;
    got_chars.delete();
    got_addrs.delete();
    if (mode == 1) bus.char_ready = 1'b0;
    checking = 1;
    en_state = 4'd6;
    if (mode == 2) begin
      for (k = 0; k < 100; k++) begin
        @(posedge clk); #1;
        if (bus.bit_ready) break;
      end
      chk({tname, "_reached_walk"}, bus.bit_ready, 1);
      en_state = 4'd3;
      feed = stim;
      feed_epoch++;
      bus.stream_done = 1'b1;
      repeat (4) @(posedge clk);
      #1 en_state = 4'd6;
    end else begin
      feed = stim;
      feed_epoch++;
      bus.stream_done = 1'b1;
    end
    if (mode == 1) begin
      for (k = 0; k < 100; k++) begin
        @(posedge clk); #1;
        if (bus.char_valid) break;
      end
      repeat (10) @(posedge clk);
      #1;
      chk({tname, "_stall_valid"}, bus.char_valid, 1);
      chk({tname, "_stall_char"},  bus.char_out,   8'h41);
      chk({tname, "_stall_count"}, char_count,     0);
      bus.char_ready = 1'b1;
    end
    for (k = 0; k < 2000; k++) begin
      @(posedge clk); #1;
      if (finished || error) break;
    end
    chk({tname, "_terminated"}, finished || error, 1);
    repeat (8) @(posedge clk);
    #1 checking = 0;
    chk({tname, "_chars_total"}, ci,         exp_chars.size());
    chk({tname, "_reads_total"}, ai,         exp_addrs.size());
    chk({tname, "_finished"},    finished,   exp_fin);
    chk({tname, "_error"},       error,      exp_err);
    chk({tname, "_count_final"}, char_count, exp_chars.size());
  endtask

  initial begin
    rst = 1'b1;
    en_state = 4'd0;
    max_index = 7'd4;
    bus.stream_done = 1'b0;
    bus.char_ready  = 1'b1;

    // Three-node tree: root 4 -> 'A' / 'B'; bits 0,1,1
    clear_tree();
    tl[4] = 9'h041; tr[4] = 9'h042;
    stim = {1'b0, 1'b1, 1'b1};
    run_test("t1", 7'd4, 0, 0);
    chk("t1_c0", gc(0), 8'h41);
    chk("t1_c1", gc(1), 8'h42);
    chk("t1_c2", gc(2), 8'h42);
    chk("t1_count", char_count, 16'd3);
    chk("t1_finished", finished, 1);

    // Same tree, 5-cycle SRAM latency
    run_test("t3", 7'd4, 5, 0);
    chk("t3_c0", gc(0), 8'h41);
    chk("t3_c2", gc(2), 8'h42);
    chk("t3_count", char_count, 16'd3);

    // char_ready held low in EMIT
    run_test("t4", 7'd4, 0, 1);
    chk("t4_c1", gc(1), 8'h42);

    // Two-level tree: root right -> internal 3 (addr 6); bits 1,0
    clear_tree();
    tl[4] = 9'h041; tr[4] = 9'h103;
    tl[6] = 9'h043; tr[6] = 9'h044;
    stim = {1'b1, 1'b0};
    run_test("t2", 7'd4, 0, 0);
    chk("t2_a0", ga(0), 7'd4);
    chk("t2_a1", ga(1), 7'd6);
    chk("t2_a2", ga(2), 7'd4);
    chk("t2_c0", gc(0), 8'h43);

    // Same, frozen for 4 cycles in WALK
    run_test("t6", 7'd4, 0, 2);
    chk("t6_a1", ga(1), 7'd6);
    chk("t6_c0", gc(0), 8'h43);
    chk("t6_finished", finished, 1);

    // Truncated code: stream ends at node 6
    stim = {1'b1};
    run_test("t7", 7'd4, 0, 0);
    chk("t7_error", error, 1);
    chk("t7_count", char_count, 16'd0);

    // Null child selected at root
    clear_tree();
    tl[4] = 9'h180; tr[4] = 9'h042;
    stim = {1'b0};
    run_test("t5", 7'd4, 0, 0);
    chk("t5_error", error, 1);
    chk("t5_reads", rd_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
